// File: rtl/alu_mdu.sv
// alu_mdu -- MIPS EX-stage ALU with an iterative radix-2 multiply/divide unit.
//
// Purpose: single-cycle logic, arithmetic, shift and HI/LO-move results are
// produced combinationally on y.  MULT/MULTU/DIV/DIVU run on a shift-add /
// restoring-divide engine that takes WIDTH cycles and writes {hi, lo}.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   a, b           operands (b already extended for I-type)
//   hi, lo         current HI/LO register values (for MFHI/MFLO)
//   sa             instruction shift amount
//   op             8-bit EXE_*_OP code
//   valid_i        op is a live instruction
//   flush          synchronous cancel of any MDU operation
//   y              combinational result
//   overflow       signed overflow of ADD/ADDI/SUB
//   stall_o        hold EX stage and upstream while the MDU is busy
//   hilo_o         registered {hi, lo} MDU result
//   hilo_we        one-cycle HI/LO write strobe
//
// Optional feature: define ALU_OVF_EN to build the overflow detector;
// otherwise overflow is tied to 0.

module alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SA_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    input  logic [SA_W-1:0]    sa,
    input  logic [7:0]         op,
    input  logic               valid_i,
    input  logic               flush,
    output logic [WIDTH-1:0]   y,
    output logic               overflow,
    output logic               stall_o,
    output logic [2*WIDTH-1:0] hilo_o,
    output logic               hilo_we
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IMM_W = (WIDTH < 16) ? WIDTH : 16;

    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
    localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
    localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       opnd_q;
    logic                   is_div_q, neg_q_q, neg_r_q, div_zero_q;

    logic                   is_md, is_sgn, is_div, start;
    logic [WIDTH-1:0]       sum, diff, imm_z, a_mag, b_mag;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]         mul_sum, div_trial;
    logic [2*WIDTH-1:0]     step_next;

    // Signs of the raw operands drive the final correction: quotient/product
    // negate on differing signs, remainder follows the dividend.  A zero
    // divisor keeps the all-ones quotient the restoring loop naturally yields.
    function automatic logic [2*WIDTH-1:0] sign_fix(
        input logic [2*WIDTH-1:0] raw,
        input logic               div,
        input logic               neg_q,
        input logic               neg_r,
        input logic               dz
    );
        logic [WIDTH-1:0] q, r;
        if (!div) begin
            sign_fix = neg_q ? -raw : raw;
        end else begin
            q = raw[WIDTH-1:0];
            r = raw[2*WIDTH-1:WIDTH];
            if (dz)
                q = '1;
            else if (neg_q)
                q = -q;
            if (neg_r)
                r = -r;
            sign_fix = {r, q};
        end
    endfunction

    assign a_s   = a;
    assign b_s   = b;
    assign sum   = a + b;
    assign diff  = a - b;
    assign is_md  = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
                    (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    assign is_sgn = (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    assign is_div = (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    assign a_mag  = (is_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (is_sgn && b[WIDTH-1]) ? -b : b;
    assign start  = (state_q == IDLE) && valid_i && is_md && !flush;

    always_comb begin
        imm_z = '0;
        imm_z[IMM_W-1:0] = b[IMM_W-1:0];
    end

    always_comb begin
        y = '0;
        case (op)
            EXE_AND_OP:                 y = a & b;
            EXE_OR_OP:                  y = a | b;
            EXE_XOR_OP:                 y = a ^ b;
            EXE_NOR_OP:                 y = ~(a | b);
            EXE_ANDI_OP:                y = a & imm_z;
            EXE_ORI_OP:                 y = a | imm_z;
            EXE_XORI_OP:                y = a ^ imm_z;
            EXE_LUI_OP:                 y = imm_z << 16;
            EXE_ADD_OP, EXE_ADDU_OP,
            EXE_ADDI_OP, EXE_ADDIU_OP:  y = sum;
            EXE_SUB_OP, EXE_SUBU_OP:    y = diff;
            EXE_SLT_OP, EXE_SLTI_OP:    y = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            EXE_SLTU_OP, EXE_SLTIU_OP:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            EXE_SLL_OP:                 y = b << sa;
            EXE_SRL_OP:                 y = b >> sa;
            EXE_SRA_OP:                 y = b_s >>> sa;
            EXE_SLLV_OP:                y = b << a[SA_W-1:0];
            EXE_SRLV_OP:                y = b >> a[SA_W-1:0];
            EXE_SRAV_OP:                y = b_s >>> a[SA_W-1:0];
            EXE_MFHI_OP:                y = hi;
            EXE_MFLO_OP:                y = lo;
            default:                    y = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    always_comb begin
        overflow = 1'b0;
        case (op)
            EXE_ADD_OP, EXE_ADDI_OP:
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            EXE_SUB_OP:
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default:
                overflow = 1'b0;
        endcase
    end
`else
    assign overflow = 1'b0;
`endif

    // One engine step: mult keeps {partial, multiplier} and shifts right;
    // div keeps {remainder, dividend/quotient} and shifts left.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    always_comb begin
        step_next = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q)
            step_next = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                         : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUSY;
            BUSY:    if (count_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    assign stall_o = start || (state_q == BUSY);
    assign hilo_we = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            hilo_o  <= '0;
        end else begin
            state_q <= state_d;
            if (start)
                count_q <= CNT_W'(WIDTH);
            else if (state_q == BUSY)
                count_q <= count_q - CNT_W'(1);
            if (state_q == BUSY && count_q == CNT_W'(1) && !flush)
                hilo_o <= sign_fix(step_next, is_div_q, neg_q_q, neg_r_q, div_zero_q);
        end
    end

    // Datapath registers carry no reset; they are always loaded on start.
    always_ff @(posedge clk) begin
        if (start) begin
            acc_q      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_q     <= is_div ? b_mag : a_mag;
            is_div_q   <= is_div;
            neg_q_q    <= is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_q    <= is_sgn && a[WIDTH-1];
            div_zero_q <= (b == '0);
        end else if (state_q == BUSY) begin
            acc_q      <= step_next;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: WIDTH=32 main instance plus a WIDTH=16 one.
module tb_alu_mdu;
    localparam logic [7:0] OP_AND  = 8'b0010_0100, OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_ANDI = 8'b0101_1001, OP_LUI  = 8'b0101_1100;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100, OP_SLLV = 8'b0000_0100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010, OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SRAV = 8'b0000_0111, OP_MFHI = 8'b0001_0000;
    localparam logic [7:0] OP_MFLO = 8'b0001_0010, OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011, OP_ADD  = 8'b0010_0000;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001, OP_SUB  = 8'b0010_0010;
    localparam logic [7:0] OP_MULT = 8'b0001_1000, OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010, OP_DIVU = 8'b0001_1011;
`ifdef ALU_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] a = '0, b = '0, hi = '0, lo = '0;
    logic [4:0]  sa = '0;
    logic [7:0]  op = 8'hFF;
    logic        valid_i = 1'b0, flush = 1'b0;
    logic [31:0] y;
    logic        overflow, stall_o, hilo_we;
    logic [63:0] hilo_o;

    logic [15:0] a16 = '0, b16 = '0, z16 = '0;
    logic [3:0]  sa16 = '0;
    logic [7:0]  op16 = 8'hFF;
    logic        valid16 = 1'b0, flush16 = 1'b0;
    logic [15:0] y16;
    logic        ovf16, stall16, we16;
    logic [31:0] hilo16;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .hi(hi), .lo(lo), .sa(sa), .op(op),
        .valid_i(valid_i), .flush(flush), .y(y), .overflow(overflow),
        .stall_o(stall_o), .hilo_o(hilo_o), .hilo_we(hilo_we)
    );

    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .hi(z16), .lo(z16), .sa(sa16), .op(op16),
        .valid_i(valid16), .flush(flush16), .y(y16), .overflow(ovf16),
        .stall_o(stall16), .hilo_o(hilo16), .hilo_we(we16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        stall;
        logic        we;
        logic        chk_hilo;
        logic [63:0] hilo;
    } probe_t;

    probe_t      probe_q[$];
    string       pname_q[$];
    logic [63:0] md_q[$];
    string       mdname_q[$];
    logic [31:0] md16_q[$];
    logic        probe = 1'b0;
    int          tests = 0, fails = 0;
    int          stall_cnt = 0, stall16_cnt = 0;
    logic [63:0] last_hilo = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: probes compare the instantaneous outputs; every hilo_we pops
    // one MD result and checks the stall run that preceded it.
    always @(negedge clk) begin
        probe_t e;
        string  nm;
        if (probe && probe_q.size() > 0) begin
            e  = probe_q.pop_front();
            nm = pname_q.pop_front();
            check({nm, ".y"}, {32'd0, y}, {32'd0, e.y});
            check({nm, ".ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
            check({nm, ".stall"}, {63'd0, stall_o}, {63'd0, e.stall});
            check({nm, ".we"}, {63'd0, hilo_we}, {63'd0, e.we});
            if (e.chk_hilo)
                check({nm, ".hilo"}, hilo_o, e.hilo);
        end
        if (hilo_we) begin
            if (md_q.size() == 0) begin
                check("unexpected_hilo_we", 64'd1, 64'd0);
            end else begin
                nm = mdname_q.pop_front();
                check({nm, ".hilo"}, hilo_o, md_q.pop_front());
                check({nm, ".stall_cycles"}, 64'(stall_cnt), 64'd33);
                check({nm, ".stall_done"}, {63'd0, stall_o}, 64'd0);
            end
            stall_cnt = 0;
        end else if (stall_o) begin
            stall_cnt++;
        end else begin
            stall_cnt = 0;
        end

        if (we16) begin
            if (md16_q.size() == 0)
                check("w16.unexpected_we", 64'd1, 64'd0);
            else begin
                check("w16.hilo", {32'd0, hilo16}, {32'd0, md16_q.pop_front()});
                check("w16.stall_cycles", 64'(stall16_cnt), 64'd17);
            end
            stall16_cnt = 0;
        end else if (stall16) begin
            stall16_cnt++;
        end else begin
            stall16_cnt = 0;
        end
    end

    task automatic push_probe(input string nm, input logic [31:0] ey, input logic eo,
                              input logic es, input logic ew, input logic ch, input logic [63:0] eh);
        probe_t e;
        e.y = ey; e.ovf = eo; e.stall = es; e.we = ew; e.chk_hilo = ch; e.hilo = eh;
        probe_q.push_back(e);
        pname_q.push_back(nm);
        probe = 1'b1;
    endtask

    task automatic comb(input string nm, input logic [7:0] o, input logic [31:0] ia,
                        input logic [31:0] ib, input logic [4:0] isa,
                        input logic [31:0] ey, input logic eo);
        @(posedge clk); #1;
        op = o; a = ia; b = ib; sa = isa; valid_i = 1'b1;
        push_probe(nm, ey, eo, 1'b0, 1'b0, 1'b0, 64'd0);
        @(negedge clk); #1;
        probe = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic md(input string nm, input logic [7:0] o, input logic [31:0] ia,
                      input logic [31:0] ib, input logic [63:0] eh);
        bit done = 0;
        @(posedge clk); #1;
        op = o; a = ia; b = ib; valid_i = 1'b1;
        md_q.push_back(eh);
        mdname_q.push_back(nm);
        last_hilo = eh;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (!stall_o) begin
                done = 1;
                break;
            end
        end
        valid_i = 1'b0;
        op = 8'hFF;
        if (!done)
            check({nm, ".timeout"}, 64'd1, 64'd0);
        @(negedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with an unknown op on the inputs.
        #2;
        push_probe("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
        @(negedge clk); #1;
        probe = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        comb("srav", OP_SRAV, 32'h21, 32'h8000_0000, 5'd0, 32'hC000_0000, 1'b0);
        hi = 32'h0000_DEAD; lo = 32'h0000_1234;
        comb("mflo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'h0000_1234, 1'b0);
        comb("mfhi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'h0000_DEAD, 1'b0);
        comb("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, OVF);
        comb("addu_noovf", OP_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
        comb("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, OVF);
        comb("sub_plain", OP_SUB, 32'd10, 32'd3, 5'd0, 32'd7, 1'b0);
        comb("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        comb("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0);
        comb("and", OP_AND, 32'hF0F0_1234, 32'hFF00_FF00, 5'd0, 32'hF000_1200, 1'b0);
        comb("nor", OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd0, 32'h0000_0F0F, 1'b0);
        comb("andi", OP_ANDI, 32'hFFFF_FFFF, 32'hFFFF_8001, 5'd0, 32'h0000_8001, 1'b0);
        comb("lui", OP_LUI, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
        comb("sll", OP_SLL, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
        comb("srl", OP_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
        comb("sra", OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
        comb("sllv", OP_SLLV, 32'h23, 32'd1, 5'd0, 32'd8, 1'b0);
        comb("unknown", 8'hFF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 32'd0, 1'b0);

        md("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        md("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        md("div_negdiv", OP_DIV, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);
        md("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        md("divu_zero", OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        md("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        md("divu_plain", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);

        // Flush a DIVU in cycle 10; nothing must be written.
        @(posedge clk); #1;
        op = OP_DIVU; a = 32'd100; b = 32'd3; valid_i = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            probe = 1'b0;
            if (k == 5)
                push_probe("md_busy", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
            if (k == 10)
                flush = 1'b1;
            if (k == 11) begin
                flush = 1'b0;
                valid_i = 1'b0;
                op = 8'hFF;
                push_probe("flush", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, last_hilo);
            end
        end
        @(negedge clk); #1;
        probe = 1'b0;
        repeat (40) @(posedge clk);

        // Asynchronous reset in cycle 5 of a MULT.
        #1;
        op = OP_MULT; a = 32'd5; b = 32'd6; valid_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        valid_i = 1'b0;
        op = 8'hFF;
        push_probe("rst_mid", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
        @(negedge clk); #1;
        probe = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);

        // WIDTH=16 build: MULTU 0xFFFF * 0xFFFF.
        #1;
        op16 = OP_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF; valid16 = 1'b1;
        md16_q.push_back(32'hFFFE_0001);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
        end
        valid16 = 1'b0;
        op16 = 8'hFF;
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("md_queue_drained", 64'(md_q.size()), 64'd0);
        check("md16_queue_drained", 64'(md16_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage ALU with an integrated iterative multiply/divide unit (MDU), for the MIPS pipeline's EX stage. Single-cycle logic, arithmetic, shift and HI/LO-move ops are combinational. MULT/MULTU/DIV/DIVU run on a multi-cycle radix-2 engine that stalls the pipeline and writes a double-width HI/LO result. Op encodings come from `defines.vh` (`EXE_*_OP`, 8-bit).

## Interface
- WIDTH, 32, datapath width; even, ≥ 8.
- SA_W, $clog2(WIDTH), localparam; shift-amount width.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a, b  in  WIDTH  operands (b already sign/zero-extended for I-type)
- hi, lo  in  WIDTH  current HI/LO register values
- sa  in  SA_W  instruction shift amount
- op  in  8  `EXE_*_OP` code
- valid_i  in  1  op is a live instruction (low for bubbles)
- flush  in  1  synchronous cancel of any MDU operation
- y  out  WIDTH  combinational result
- overflow  out  1  signed overflow (see Configuration)
- stall_o  out  1  hold EX stage and upstream
- hilo_o  out  2·WIDTH  {hi, lo} MDU result, registered
- hilo_we  out  1  one-cycle HI/LO write strobe

## Operation
- Combinational ops: AND/OR/XOR/NOR; ANDI/ORI/XORI zero-extend b[15:0]; LUI = {b[15:0], 0}; ADD/ADDU/ADDI/ADDIU = a+b; SUB/SUBU = a−b; SLT/SLTI signed, SLTU/SLTIU unsigned, result 0/1 zero-extended.
- Shifts: SLL/SRL/SRA by sa; SLLV/SRLV/SRAV by a[SA_W-1:0] only (upper bits ignored).
- MFHI: y = hi; MFLO: y = lo. Unknown op: y = 0.
- MD ops (MULT, MULTU, DIV, DIVU): y = 0; engine FSM IDLE → BUSY → DONE → IDLE.
  - IDLE: if valid_i & MD op & !flush → latch operand magnitudes (absolute values for signed ops, with sign flags), count = WIDTH, → BUSY.
  - BUSY: one shift-add (mult) or restoring subtract-shift (div) step per cycle; count decrements; at count = 1 apply sign fix, load hilo_o, → DONE.
  - DONE: hilo_we = 1 for this cycle; new starts ignored; → IDLE.
- Mult: hilo_o = full 2·WIDTH product; negated if signed and operand signs differ.
- Div: lo = quotient, hi = remainder; signed quotient negated if signs differ, remainder takes dividend sign. Most-negative dividend handled via unsigned magnitude (−2^(W−1)/−1 gives lo = 0x8000_0000, hi = 0 at W=32).
- Divide by zero: full latency; lo = all-ones, hi = a (both signed and unsigned).
- flush: any state → IDLE next edge; hilo_o unchanged; no hilo_we. Flush has priority over start.
- hilo_o holds the last completed result until the next DONE.

## Timing
- Reset: state IDLE, count 0, hilo_o = 0, hilo_we = 0, stall_o = 0, overflow 0; y follows inputs combinationally (0 for default op).
- Combinational ops: 0-cycle latency, never stall.
- stall_o = (IDLE & valid_i & MD op & !flush) | BUSY. Cycle 0 = accept cycle; stall_o high cycles 0..WIDTH; DONE at cycle WIDTH+1 with stall_o = 0 and hilo_we = 1; earliest next MD start cycle WIDTH+2.
- Pipeline holds op/operands stable while stall_o = 1; engine uses latched copies only after cycle 0.
- Reset mid-operation: immediate IDLE, no hilo_we.

## Configuration
- ALU_OVF_EN defined: overflow = signed overflow of ADD/ADDI (same-sign operands, result sign differs) or SUB (opposite signs, result sign ≠ a); 0 for every other op, including ADDU/ADDIU/SUBU. y is still driven (exception logic downstream discards it).
- Undefined: overflow tied to 0; no overflow logic synthesised.

## Test plan
- WIDTH=32, MULT a=0xFFFF_FFFE, b=3 → stall_o high cycles 0–32, cycle 33 hilo_we=1, hilo_o=0xFFFF_FFFF_FFFF_FFFA.
- DIV a=0xFFFF_FFF9 (−7), b=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU a=7, b=0 → lo=0xFFFF_FFFF, hi=7, same 33-cycle latency.
- SRAV a=0x21, b=0x8000_0000 → y=0xC000_0000 same cycle, stall_o=0; MFLO lo=0x1234 → y=0x1234.
- DIVU started, flush asserted cycle 10 → state IDLE cycle 11, stall_o=0, no hilo_we, hilo_o unchanged; rst at cycle 5 of a MULT → hilo_o=0, stall_o=0 immediately.
- ALU_OVF_EN: ADD 0x7FFF_FFFF+1 → overflow=1, y=0x8000_0000; ADDU same → overflow=0; SUB 0x8000_0000−1 → overflow=1. Without macro all → 0.
- WIDTH=16 build: MULTU 0xFFFF×0xFFFF → hilo_o=0xFFFE_0001 at cycle 17.
